// File: rtl/mem_access_if.sv
// Bus between the EX/MEM pipeline register and the memory-access stage.
// The master drives the instruction fields; the slave returns write-back data and the stall.
interface mem_access_if;
    logic        i_reg_write;
    logic [1:0]  i_mem_to_reg;
    logic        i_mem_read;
    logic        i_mem_write;
    logic [31:0] i_pc_4;
    logic [31:0] i_alu_out;
    logic [31:0] i_data_2;
    logic [5:0]  i_write_register;
    logic        o_reg_write;
    logic [5:0]  o_write_register;
    logic [31:0] o_write_data;
    logic        o_stall;

    modport master (
        output i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write,
        output i_pc_4, i_alu_out, i_data_2, i_write_register,
        input  o_reg_write, o_write_register, o_write_data, o_stall
    );

    modport slave (
        input  i_reg_write, i_mem_to_reg, i_mem_read, i_mem_write,
        input  i_pc_4, i_alu_out, i_data_2, i_write_register,
        output o_reg_write, o_write_register, o_write_data, o_stall
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: word RAM with a configurable number of wait states.
// Optional macro MMIO_CYCLE_COUNTER_EN maps a free-running cycle counter at 0x40000000.
module mem_access_stage #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    mem_access_if.slave bus
);
    localparam int         ADDR_W   = $clog2(DEPTH_WORDS);
    localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        stall, commit;

    logic [31:0]       mem [DEPTH_WORDS];
    logic [ADDR_W-1:0] word_idx;
    logic              in_range, access, is_store, mmio_hit, zero_wait;
    logic [31:0]       load_data, wb_data;

    logic        reg_write_p1;
    logic [5:0]  write_register_p1;
    logic [31:0] write_data_p1;

    assign word_idx = bus.i_alu_out[ADDR_W+1:2];
    assign in_range = ~|bus.i_alu_out[31:ADDR_W+2];
    assign access   = bus.i_mem_read | bus.i_mem_write;
    assign is_store = bus.i_mem_write;

`ifdef MMIO_CYCLE_COUNTER_EN
    localparam logic [31:0] MMIO_ADDR = 32'h4000_0000;
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cycle_cnt <= '0;
        else        cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign mmio_hit = (bus.i_alu_out == MMIO_ADDR);
`else
    assign mmio_hit = 1'b0;
`endif

    // Counter reads are register-speed, so they skip the RAM wait states.
    assign zero_wait = (WAIT_STATES == 0) || (mmio_hit && !is_store);

    always_comb begin
        load_data = '0;
        if (in_range) load_data = mem[word_idx];
`ifdef MMIO_CYCLE_COUNTER_EN
        if (mmio_hit) load_data = cycle_cnt;
`endif
    end

    always_comb begin
        case (bus.i_mem_to_reg)
            2'b01:   wb_data = load_data;
            2'b10:   wb_data = bus.i_pc_4;
            default: wb_data = bus.i_alu_out;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    if (zero_wait) begin
                        commit = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != 3'd0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 3'd1;
                end else begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RAM is never cleared; a store lands only on its commit edge.
    always_ff @(posedge clk) begin
        if (reset && commit && is_store && in_range && !mmio_hit)
            mem[word_idx] <= bus.i_data_2;
    end

    // Stage boundary p0 -> p1: write-back registers, bubble on every stalled edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_write_p1      <= 1'b0;
            write_register_p1 <= 6'd0;
            write_data_p1     <= 32'd0;
        end else if (stall) begin
            reg_write_p1      <= 1'b0;
            write_register_p1 <= 6'd0;
            write_data_p1     <= 32'd0;
        end else begin
            reg_write_p1      <= bus.i_reg_write;
            write_register_p1 <= bus.i_write_register;
            write_data_p1     <= wb_data;
        end
    end

    assign bus.o_stall          = stall & reset;
    assign bus.o_reg_write      = reg_write_p1;
    assign bus.o_write_register = write_register_p1;
    assign bus.o_write_data     = write_data_p1;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: one instance with two wait states, one with none.
module tb_mem_access_stage;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_access_if bus2();
    mem_access_if bus0();

    mem_access_stage #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
    mem_access_stage #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    function automatic logic get_stall(input bit use0);
        return use0 ? bus0.o_stall : bus2.o_stall;
    endfunction
    function automatic logic get_rw(input bit use0);
        return use0 ? bus0.o_reg_write : bus2.o_reg_write;
    endfunction
    function automatic logic [5:0] get_wreg(input bit use0);
        return use0 ? bus0.o_write_register : bus2.o_write_register;
    endfunction
    function automatic logic [31:0] get_data(input bit use0);
        return use0 ? bus0.o_write_data : bus2.o_write_data;
    endfunction

    task automatic set_in(input bit use0, input logic rd, input logic wr, input logic [1:0] m2r,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc4,
                          input logic rw, input logic [5:0] wreg);
        if (use0) begin
            bus0.i_mem_read = rd; bus0.i_mem_write = wr; bus0.i_mem_to_reg = m2r;
            bus0.i_alu_out = addr; bus0.i_data_2 = wdata; bus0.i_pc_4 = pc4;
            bus0.i_reg_write = rw; bus0.i_write_register = wreg;
        end else begin
            bus2.i_mem_read = rd; bus2.i_mem_write = wr; bus2.i_mem_to_reg = m2r;
            bus2.i_alu_out = addr; bus2.i_data_2 = wdata; bus2.i_pc_4 = pc4;
            bus2.i_reg_write = rw; bus2.i_write_register = wreg;
        end
    endtask

    // Presents one instruction at posedge+1, holds it through the stall, returns the
    // stall-cycle count, whether every stalled edge produced a bubble, and the write-back.
    task automatic access(input bit use0, input logic rd, input logic wr, input logic [1:0] m2r,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] pc4,
                          input logic rw, input logic [5:0] wreg,
                          output int stalls, output bit bubble_ok,
                          output logic orw, output logic [5:0] owreg, output logic [31:0] odata);
        set_in(use0, rd, wr, m2r, addr, wdata, pc4, rw, wreg);
        #1;
        stalls = 0;
        bubble_ok = 1'b1;
        while (get_stall(use0) === 1'b1 && stalls < 10) begin
            stalls++;
            @(posedge clk); #1;
            if (get_rw(use0) !== 1'b0 || get_wreg(use0) !== 6'd0 || get_data(use0) !== 32'd0)
                bubble_ok = 1'b0;
        end
        @(posedge clk); #1;
        orw = get_rw(use0);
        owreg = get_wreg(use0);
        odata = get_data(use0);
        set_in(use0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0);
    endtask

    int          st;
    bit          bok;
    logic        orw;
    logic [5:0]  owreg;
    logic [31:0] odata;

    task automatic test_reset();
        reset = 1'b0;
        set_in(1'b0, 1'b1, 1'b0, 2'b01, 32'h10, 32'd0, 32'd0, 1'b1, 6'd3);
        set_in(1'b1, 1'b1, 1'b0, 2'b01, 32'h10, 32'd0, 32'd0, 1'b1, 6'd3);
        @(posedge clk); #1;
        total++; if (bus2.o_stall !== 1'b0) begin bad++; $display("FAIL rst_stall2 got=%h want=0", bus2.o_stall); end
        total++; if (bus2.o_reg_write !== 1'b0) begin bad++; $display("FAIL rst_rw2 got=%h want=0", bus2.o_reg_write); end
        total++; if (bus2.o_write_register !== 6'd0) begin bad++; $display("FAIL rst_wreg2 got=%h want=0", bus2.o_write_register); end
        total++; if (bus2.o_write_data !== 32'd0) begin bad++; $display("FAIL rst_data2 got=%h want=0", bus2.o_write_data); end
        total++; if (bus0.o_stall !== 1'b0) begin bad++; $display("FAIL rst_stall0 got=%h want=0", bus0.o_stall); end
        total++; if (bus0.o_write_data !== 32'd0) begin bad++; $display("FAIL rst_data0 got=%h want=0", bus0.o_write_data); end
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0);
        set_in(1'b1, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0);
        reset = 1'b1;
    endtask

    task automatic test_store_wait();
        access(1'b0, 1'b0, 1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 6'd0, st, bok, orw, owreg, odata);
        total++; if (st !== 2) begin bad++; $display("FAIL store_stalls got=%0d want=2", st); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL store_bubble got=%0d want=1", bok); end
        total++; if (orw !== 1'b0) begin bad++; $display("FAIL store_rw got=%h want=0", orw); end
    endtask

    task automatic test_load_wait();
        access(1'b0, 1'b1, 1'b0, 2'b01, 32'h10, 32'd0, 32'h104, 1'b1, 6'd5, st, bok, orw, owreg, odata);
        total++; if (st !== 2) begin bad++; $display("FAIL load_stalls got=%0d want=2", st); end
        total++; if (bok !== 1'b1) begin bad++; $display("FAIL load_bubble got=%0d want=1", bok); end
        total++; if (orw !== 1'b1) begin bad++; $display("FAIL load_rw got=%h want=1", orw); end
        total++; if (owreg !== 6'd5) begin bad++; $display("FAIL load_wreg got=%0d want=5", owreg); end
        total++; if (odata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_data got=%h want=deadbeef", odata); end
        access(1'b0, 1'b1, 1'b0, 2'b01, 32'h13, 32'd0, 32'd0, 1'b1, 6'd9, st, bok, orw, owreg, odata);
        total++; if (odata !== 32'hDEADBEEF) begin bad++; $display("FAIL load_lowbits got=%h want=deadbeef", odata); end
    endtask

    task automatic test_passthrough();
        access(1'b0, 1'b0, 1'b0, 2'b00, 32'h11112222, 32'd0, 32'h3334, 1'b1, 6'd3, st, bok, orw, owreg, odata);
        total++; if (st !== 0) begin bad++; $display("FAIL pass_stalls got=%0d want=0", st); end
        total++; if (odata !== 32'h11112222) begin bad++; $display("FAIL pass_alu got=%h want=11112222", odata); end
        total++; if (owreg !== 6'd3 || orw !== 1'b1) begin bad++; $display("FAIL pass_ctl got=%0d/%h want=3/1", owreg, orw); end
        access(1'b0, 1'b0, 1'b0, 2'b10, 32'h11112222, 32'd0, 32'h3334, 1'b1, 6'd4, st, bok, orw, owreg, odata);
        total++; if (odata !== 32'h3334) begin bad++; $display("FAIL pass_pc4 got=%h want=3334", odata); end
        access(1'b0, 1'b0, 1'b0, 2'b11, 32'h5555AAAA, 32'd0, 32'h3334, 1'b0, 6'd4, st, bok, orw, owreg, odata);
        total++; if (odata !== 32'h5555AAAA) begin bad++; $display("FAIL pass_sel11 got=%h want=5555aaaa", odata); end
        total++; if (orw !== 1'b0) begin bad++; $display("FAIL pass_rw0 got=%h want=0", orw); end
    endtask

    task automatic test_back_to_back();
        access(1'b1, 1'b0, 1'b1, 2'b00, 32'h20, 32'h1234, 32'd0, 1'b0, 6'd0, st, bok, orw, owreg, odata);
        total++; if (st !== 0) begin bad++; $display("FAIL b2b_store_stalls got=%0d want=0", st); end
        access(1'b1, 1'b1, 1'b0, 2'b01, 32'h20, 32'd0, 32'd0, 1'b1, 6'd7, st, bok, orw, owreg, odata);
        total++; if (st !== 0) begin bad++; $display("FAIL b2b_load_stalls got=%0d want=0", st); end
        total++; if (odata !== 32'h1234) begin bad++; $display("FAIL b2b_data got=%h want=1234", odata); end
        total++; if (owreg !== 6'd7) begin bad++; $display("FAIL b2b_wreg got=%0d want=7", owreg); end
    endtask

    task automatic test_out_of_range();
        access(1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'hA5A5A5A5, 32'd0, 1'b0, 6'd0, st, bok, orw, owreg, odata);
        access(1'b0, 1'b1, 1'b0, 2'b01, 32'h400, 32'd0, 32'd0, 1'b1, 6'd2, st, bok, orw, owreg, odata);
        total++; if (st !== 2) begin bad++; $display("FAIL oor_load_stalls got=%0d want=2", st); end
        total++; if (odata !== 32'd0) begin bad++; $display("FAIL oor_load_data got=%h want=0", odata); end
        access(1'b0, 1'b0, 1'b1, 2'b00, 32'h400, 32'h55, 32'd0, 1'b0, 6'd0, st, bok, orw, owreg, odata);
        access(1'b0, 1'b0, 1'b1, 2'b00, 32'h410, 32'h66, 32'd0, 1'b0, 6'd0, st, bok, orw, owreg, odata);
        access(1'b0, 1'b1, 1'b0, 2'b01, 32'h0, 32'd0, 32'd0, 1'b1, 6'd2, st, bok, orw, owreg, odata);
        total++; if (odata !== 32'hA5A5A5A5) begin bad++; $display("FAIL oor_word0 got=%h want=a5a5a5a5", odata); end
        access(1'b0, 1'b1, 1'b0, 2'b01, 32'h10, 32'd0, 32'd0, 1'b1, 6'd2, st, bok, orw, owreg, odata);
        total++; if (odata !== 32'hDEADBEEF) begin bad++; $display("FAIL oor_word4 got=%h want=deadbeef", odata); end
        access(1'b1, 1'b1, 1'b0, 2'b01, 32'h420, 32'd0, 32'd0, 1'b1, 6'd2, st, bok, orw, owreg, odata);
        total++; if (odata !== 32'd0) begin bad++; $display("FAIL oor_load_ws0 got=%h want=0", odata); end
    endtask

    task automatic test_reset_mid_wait();
        set_in(1'b0, 1'b0, 1'b1, 2'b00, 32'h10, 32'h00000BAD, 32'd0, 1'b1, 6'd6);
        @(posedge clk); #1;
        reset = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b0, 6'd0);
        #1;
        total++; if (bus2.o_stall !== 1'b0) begin bad++; $display("FAIL rmw_stall got=%h want=0", bus2.o_stall); end
        @(posedge clk); #1;
        total++; if (bus2.o_reg_write !== 1'b0 || bus2.o_write_register !== 6'd0) begin bad++; $display("FAIL rmw_ctl got=%h/%0d want=0/0", bus2.o_reg_write, bus2.o_write_register); end
        total++; if (bus2.o_write_data !== 32'd0) begin bad++; $display("FAIL rmw_data got=%h want=0", bus2.o_write_data); end
        reset = 1'b1;
        access(1'b0, 1'b1, 1'b0, 2'b01, 32'h10, 32'd0, 32'd0, 1'b1, 6'd1, st, bok, orw, owreg, odata);
        total++; if (st !== 2) begin bad++; $display("FAIL rmw_idle_stalls got=%0d want=2", st); end
        total++; if (odata !== 32'hDEADBEEF) begin bad++; $display("FAIL rmw_word got=%h want=deadbeef", odata); end
        access(1'b1, 1'b1, 1'b0, 2'b01, 32'h20, 32'd0, 32'd0, 1'b1, 6'd1, st, bok, orw, owreg, odata);
        total++; if (odata !== 32'h1234) begin bad++; $display("FAIL rmw_retain got=%h want=1234", odata); end
    endtask

    task automatic test_mmio();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        access(1'b0, 1'b1, 1'b0, 2'b01, 32'h40000000, 32'd0, 32'd0, 1'b1, 6'd8, st, bok, orw, owreg, odata);
`ifdef MMIO_CYCLE_COUNTER_EN
        total++; if (st !== 0) begin bad++; $display("FAIL mmio_stalls got=%0d want=0", st); end
        total++; if (odata !== 32'd10) begin bad++; $display("FAIL mmio_data got=%0d want=10", odata); end
`else
        total++; if (st !== 2) begin bad++; $display("FAIL mmio_stalls got=%0d want=2", st); end
        total++; if (odata !== 32'd0) begin bad++; $display("FAIL mmio_data got=%h want=0", odata); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_wait();
        test_load_wait();
        test_passthrough();
        test_back_to_back();
        test_out_of_range();
        test_reset_mid_wait();
        test_mmio();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
